mtimer_responder: RTL

Memory-mapped machine timer peripheral that answers CPU data-bus loads/stores to the `mtime`/`mtimecmp` address window and drives the machine timer interrupt pending line into the CSR unit's `mip.mtip`. It is the bus-side responder for the `MTIME_*`/`MTIMECMP_*` addresses defined in `riscV_unrn_pkg`, and the source of `M_TIMER_INT`. It sits between the data-memory interface, through an address decode, and the CSR/trap logic.

---
 rtl/mtimer_responder_if.sv | 21 ++
 rtl/mtimer_responder.sv | 93 +++++++++
 2 files changed

// File: rtl/mtimer_responder_if.sv
// Request/response bus between the data-memory address decode and the machine timer.
interface mtimer_responder_if;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/mtimer_responder.sv
// Memory-mapped mtime/mtimecmp responder with prescaled time base and registered mtip.
module mtimer_responder #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                count_en_i,
  mtimer_responder_if.slave   bus,
  output logic                mtip_o
);

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI
  } sel_e;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] pre;
  sel_e        sel;
  logic [31:0] rd_mux;
  logic        wr;
  logic        mtime_wr;

  // Exact word match; misaligned or non-word accesses never decode.
  always_comb begin
    sel = SEL_NONE;
    if (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] == 2'b00) begin
      unique case (bus.req_addr_i)
        32'h0000_8004: sel = SEL_MTIME_LO;
        32'h0000_8008: sel = SEL_MTIME_HI;
        32'h0000_800C: sel = SEL_CMP_LO;
        32'h0000_8010: sel = SEL_CMP_HI;
        default:       sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_MTIME_LO: rd_mux = mtime[31:0];
      SEL_MTIME_HI: rd_mux = mtime[63:32];
      SEL_CMP_LO:   rd_mux = mtimecmp[31:0];
      SEL_CMP_HI:   rd_mux = mtimecmp[63:32];
      default:      rd_mux = '0;
    endcase
  end

  assign wr       = bus.req_valid_i && bus.req_we_i;
  assign mtime_wr = wr && (sel == SEL_MTIME_LO || sel == SEL_MTIME_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime           <= '0;
      mtimecmp        <= '1;
      pre             <= '0;
      mtip_o          <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      bus.rsp_valid_o <= bus.req_valid_i;
      bus.rsp_err_o   <= bus.req_valid_i && (sel == SEL_NONE);
      bus.rsp_rdata_o <= (bus.req_valid_i && !bus.req_we_i) ? rd_mux : '0;

      mtip_o <= (mtime >= mtimecmp);

      // A store to mtime overrides any increment due this cycle and restarts the prescaler.
      if (mtime_wr) begin
        if (sel == SEL_MTIME_LO) mtime[31:0]  <= bus.req_wdata_i;
        else                     mtime[63:32] <= bus.req_wdata_i;
        pre <= '0;
      end else if (count_en_i) begin
        if (pre == PRE_LAST) begin
          mtime <= mtime + 64'd1;
          pre   <= '0;
        end else begin
          pre <= pre + 16'd1;
        end
      end

      if (wr && sel == SEL_CMP_LO) mtimecmp[31:0]  <= bus.req_wdata_i;
      if (wr && sel == SEL_CMP_HI) mtimecmp[63:32] <= bus.req_wdata_i;
    end
  end

endmodule
